// File: rtl/registered_adder.sv
// registered_adder: WIDTH-bit adder with carry-in, carry-out and a signed
// overflow flag. The result passes through LATENCY register stages, with a
// valid bit travelling alongside each result.
// Data registers load on every clock edge. Consumers qualify the outputs
// with out_valid. Reset clears every stage asynchronously.
module registered_adder #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             out_valid
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             overflow;
        logic             valid;
    } stage_t;

    localparam int unsigned SW = $bits(stage_t);

    logic [WIDTH:0]       full_sum;
    stage_t               stage_d;
    stage_t               stage_q;
    logic [LATENCY*SW-1:0] chain;

    // Stage 0: full-width add. The carry is taken from bit WIDTH before any
    // truncation; overflow is checked on the signs of a, b and the sum.
    always_comb begin
        full_sum          = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
        stage_d           = '0;
        stage_d.sum       = full_sum[WIDTH-1:0];
        stage_d.c_out     = full_sum[WIDTH];
        stage_d.overflow  = (a[WIDTH-1] == b[WIDTH-1]) &&
                            (full_sum[WIDTH-1] != a[WIDTH-1]);
        stage_d.valid     = in_valid;
    end

    // All stages are held in one packed shift chain so the delay depth
    // follows LATENCY without per-stage arrays. The newest result enters at
    // the low end, and the oldest leaves at the top.
    generate
        if (LATENCY == 1) begin : g_single
            // Single register stage loaded from the adder.
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) chain <= '0;
                else       chain <= stage_d;
            end
        end else begin : g_multi
            // Shift the chain by one stage each edge with no back-pressure.
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) chain <= '0;
                else       chain <= {chain[(LATENCY-1)*SW-1:0], stage_d};
            end
        end
    endgenerate

    // Drive the outputs from the oldest stage.
    always_comb begin
        stage_q   = stage_t'(chain[LATENCY*SW-1 -: SW]);
        sum       = stage_q.sum;
        c_out     = stage_q.c_out;
        overflow  = stage_q.overflow;
        out_valid = stage_q.valid;
    end

endmodule

// File: tb/tb_registered_adder.sv
// Directed bench for registered_adder. Two instances share the same inputs:
// u1 (LATENCY=1) and u3 (LATENCY=3). Expected values are hand-computed
// constants for WIDTH=8.
module tb_registered_adder;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] a, b;
    logic       c_in, in_valid;

    logic [7:0] sum1, sum3;
    logic       c_out1, c_out3, ovf1, ovf3, ov_valid1, ov_valid3;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    registered_adder #(.WIDTH(8), .LATENCY(1)) u1 (
        .Clk(Clk), .Reset(Reset), .a(a), .b(b), .c_in(c_in), .in_valid(in_valid),
        .sum(sum1), .c_out(c_out1), .overflow(ovf1), .out_valid(ov_valid1)
    );

    registered_adder #(.WIDTH(8), .LATENCY(3)) u3 (
        .Clk(Clk), .Reset(Reset), .a(a), .b(b), .c_in(c_in), .in_valid(in_valid),
        .sum(sum3), .c_out(c_out3), .overflow(ovf3), .out_valid(ov_valid3)
    );

    // Vector table: a, b, c_in, valid -> sum, c_out, overflow
    localparam int N = 10;
    logic [7:0] va   [N] = '{8'h12, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'hFF, 8'h40, 8'h80, 8'hA5, 8'hC0};
    logic [7:0] vb   [N] = '{8'h34, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h01, 8'h3F, 8'h7F, 8'h5A, 8'hC0};
    logic       vc   [N] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic       vv   [N] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
    logic [7:0] es   [N] = '{8'h46, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h80};
    logic       ec   [N] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
    logic       eo   [N] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_u1"}, {sum1, c_out1, ovf1, ov_valid1}, 64'h0);
        check({tag, "_u3"}, {sum3, c_out3, ovf3, ov_valid3}, 64'h0);
    endtask

    task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic tv);
        a = ta; b = tb; c_in = tc; in_valid = tv;
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // Reset held for two cycles with random inputs
        Reset = 1'b1;
        drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        #1;
        check_all_zero("reset_immediate");
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all_zero("reset_hold");
            drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end
        Reset = 1'b0;

        // Stream the table back to back, followed by two idle cycles for u3
        for (int i = 0; i < N + 2; i++) begin
            if (i < N) drive(va[i], vb[i], vc[i], vv[i]);
            else       drive(8'h00, 8'h00, 1'b0, 1'b0);
            tick();
            if (i < N) begin
                check("u1_sum",   64'(sum1),      64'(es[i]));
                check("u1_cout",  64'(c_out1),    64'(ec[i]));
                check("u1_ovf",   64'(ovf1),      64'(eo[i]));
                check("u1_valid", 64'(ov_valid1), 64'(vv[i]));
            end
            if (i < 2) begin
                check("u3_valid_fill", 64'(ov_valid3), 64'h0);
            end else begin
                check("u3_sum",   64'(sum3),      64'(es[i-2]));
                check("u3_cout",  64'(c_out3),    64'(ec[i-2]));
                check("u3_ovf",   64'(ovf3),      64'(eo[i-2]));
                check("u3_valid", 64'(ov_valid3), 64'(vv[i-2]));
            end
        end

        // Three valid operations in flight, then an asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) begin
            drive(va[i], vb[i], vc[i], 1'b1);
            tick();
        end
        check("u1_before_rst", {sum1, c_out1, ovf1, ov_valid1}, {8'hFF, 1'b1, 1'b0, 1'b1});
        #2;
        Reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick();
        check_all_zero("reset_edge");
        #1;
        Reset = 1'b0;

        // Idle after reset: nothing from the discarded operations may appear
        drive(8'hFF, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_u3_valid", 64'(ov_valid3), 64'h0);
            check("post_rst_u1_valid", 64'(ov_valid1), 64'h0);
        end

        // New operation: 0x7F + 0x7F + 1 = 0xFF, c_out=0, overflow=1
        drive(8'h7F, 8'h7F, 1'b1, 1'b1);
        tick();
        check("new_u1", {sum1, c_out1, ovf1, ov_valid1}, {8'hFF, 1'b0, 1'b1, 1'b1});
        check("new_u3_lat1", 64'(ov_valid3), 64'h0);
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        check("new_u3_lat2", 64'(ov_valid3), 64'h0);
        tick();
        check("new_u3", {sum3, c_out3, ovf3, ov_valid3}, {8'hFF, 1'b0, 1'b1, 1'b1});
        tick();
        check("new_u3_after", 64'(ov_valid3), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
